quadrature_encoder: RTL and testbench
=====================================

Name: quadrature_encoder

Overview:
Decodes a two-phase rotary encoder (channels A/B, quadrature Gray sequence) into single-cycle direction pulses.
- Asynchronous A/B inputs are synchronised, optionally debounced, and tracked through the 4-state Gray cycle.
- One pulse is issued on o_Left or o_Right per detent.
- Sits between the board's encoder pins and the front-panel control logic (TM1638 display/menu).

Parameters:
STEPS_PER_DETENT, 4, valid Gray transitions per output pulse; legal values 1, 2, 4.
DEBOUNCE_CYCLES, 8, consecutive stable synchronised samples required before a channel change is accepted; used only with ENCODER_DEBOUNCE_EN; minimum 1.

Ports:
i_Clk  input  1  system clock; all state on rising edge
i_Rst  input  1  asynchronous active-high reset
i_A    input  1  encoder channel A, asynchronous to i_Clk
i_B    input  1  encoder channel B, asynchronous to i_Clk
o_Left  output 1  one-cycle pulse per counter-clockwise detent
o_Right output 1  one-cycle pulse per clockwise detent

Behaviour:
- Interface: one clock, i_Clk; reset i_Rst is asynchronous and active-high.
- Reset (async assert, sync release):
  - all synchroniser flops = 0
  - filtered AB = 00
  - previous state = 00
  - step accumulator = 0
  - o_Left = o_Right = 0
- Synchroniser: 2 flops per channel. Filtered AB is the synchroniser output, or the debounced output when debounce is enabled.
- Gray state is S = {A,B}.
- Clockwise sequence: 00 -> 10 -> 11 -> 01 -> 00, i.e. A leads B. Each valid clockwise transition adds +1 to the accumulator.
- Counter-clockwise is the reverse sequence. Each valid counter-clockwise transition adds -1.
- No change: no action.
- Illegal transition (both bits change in one cycle, e.g. 00 -> 11): accumulator cleared to 0, no pulse. The previous state is still updated.
- Accumulator: signed, width ceil(log2(STEPS_PER_DETENT))+2.
  - Reaching +STEPS_PER_DETENT: o_Right pulses for 1 cycle, accumulator returns to 0.
  - Reaching -STEPS_PER_DETENT: o_Left pulses for 1 cycle, accumulator returns to 0.
- A reversal mid-detent counts back toward 0; no pulse is issued.
- o_Left and o_Right are registered and never high in the same cycle. Each pulse is exactly 1 cycle.
- Latency, debounce disabled: if an input change is captured at rising edge N, the output pulse is high during the cycle following edge N+2.
- Input changing faster than the clock can resolve: treated as an illegal transition per the rule above.
- Reset mid-detent: partial progress is discarded. A pulse already in flight is forced low immediately on reset assertion.

Optional Feature:
Macro ENCODER_DEBOUNCE_EN.
- Defined: each synchronised channel passes through an independent filter. A counter tracks cycles for which the raw sample differs from the filtered value. The filtered value flips only after DEBOUNCE_CYCLES consecutive differing samples. Any matching sample clears the counter. Latency grows by DEBOUNCE_CYCLES cycles.
- Undefined: the filter is absent; DEBOUNCE_CYCLES is ignored; latency is 3 cycles.
- Reset values are identical in both builds.

Decomposition:
- Package encoder_pkg holds:
  - the 2-bit Gray state typedef
  - direction encoding (DIR_NONE, DIR_CW, DIR_CCW, DIR_ERR)
  - a transition-decode function (prev, curr) -> direction
- One natural sub-module: encoder_debounce, instantiated once per channel and only under ENCODER_DEBOUNCE_EN.
- The synchroniser stays inline.

Test Plan:
1. Reset check: assert i_Rst with A=B=0 and random toggling -> o_Left=o_Right=0 throughout; after release, no pulse with inputs held at 00.
2. Clockwise rotation, STEPS_PER_DETENT=4, debounce off: AB 00,10,11,01,00, each held 4 cycles -> exactly one o_Right pulse, 1 cycle wide, 3 cycles after AB=00 is applied; o_Left stays 0.
3. Counter-clockwise rotation: AB 00,01,11,10,00 -> exactly one o_Left pulse. Two full CCW cycles -> two pulses.
4. Reversal and illegal transition: AB 00,10,11,10,00 -> no pulse. AB 00,11 -> no pulse and accumulator cleared; a following full CW cycle yields exactly one o_Right.
5. STEPS_PER_DETENT=1: each single CW transition -> one o_Right pulse, i.e. 4 pulses per full cycle.
6. With ENCODER_DEBOUNCE_EN and DEBOUNCE_CYCLES=8:
   - a 5-cycle glitch on A -> no state change, no pulse
   - a clean CW cycle with each step held 20 cycles -> one o_Right
   - reset asserted mid-cycle -> outputs 0, no pulse after release until a full new detent

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and the Gray-transition decoder for the quadrature encoder.
// Clockwise order of S = {A,B} is 00 -> 10 -> 11 -> 01 -> 00.
package encoder_pkg;

   typedef logic [1:0] gray_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_CW   = 2'd1,
      DIR_CCW  = 2'd2,
      DIR_ERR  = 2'd3
   } dir_e;

   function automatic gray_t cw_next(input gray_t s);
      gray_t n;
      case (s)
         2'b00:   n = 2'b10;
         2'b10:   n = 2'b11;
         2'b11:   n = 2'b01;
         default: n = 2'b00;
      endcase
      return n;
   endfunction

   // Any two-bit change is neither successor nor predecessor, so it lands on DIR_ERR.
   function automatic dir_e decode_dir(input gray_t prev, input gray_t curr);
      dir_e d;
      if (curr == prev)
         d = DIR_NONE;
      else if (curr == cw_next(prev))
         d = DIR_CW;
      else if (prev == cw_next(curr))
         d = DIR_CCW;
      else
         d = DIR_ERR;
      return d;
   endfunction

endpackage

// File: rtl/encoder_debounce.sv
// Single-channel filter: the output follows the input only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current output.
module encoder_debounce #(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_D,
   output logic o_Q
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Q <= 1'b0;
         cnt <= '0;
      end else if (i_D == o_Q) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         o_Q <= i_D;
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/quadrature_encoder.sv
// Rotary encoder decoder: synchronise A/B, track the Gray cycle, emit one
// o_Left/o_Right pulse per detent. Define ENCODER_DEBOUNCE_EN to add per-channel filters.
module quadrature_encoder
   import encoder_pkg::*;
#(
   parameter int STEPS_PER_DETENT = 4,
   parameter int DEBOUNCE_CYCLES  = 8
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_A,
   input  logic i_B,
   output logic o_Left,
   output logic o_Right
);

   localparam int ACC_W = $clog2(STEPS_PER_DETENT) + 2;
   localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(STEPS_PER_DETENT);
   localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;
   localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

   if (!(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4) ||
       DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("quadrature_encoder: illegal STEPS_PER_DETENT or DEBOUNCE_CYCLES");
   end

   gray_t sync1, sync2;
   gray_t ab_filt;
   gray_t prev;
   logic signed [ACC_W-1:0] acc, acc_next, acc_step;
   logic left_next, right_next;
   dir_e dir;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= {i_A, i_B};
         sync2 <= sync1;
      end
   end

`ifdef ENCODER_DEBOUNCE_EN
   encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_a (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .i_D   (sync2[1]),
      .o_Q   (ab_filt[1])
   );

   encoder_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce_b (
      .i_Clk (i_Clk),
      .i_Rst (i_Rst),
      .i_D   (sync2[0]),
      .o_Q   (ab_filt[0])
   );
`else
   assign ab_filt = sync2;
`endif

   always_comb begin
      dir        = decode_dir(prev, ab_filt);
      acc_next   = acc;
      acc_step   = acc;
      left_next  = 1'b0;
      right_next = 1'b0;
      case (dir)
         DIR_CW: begin
            acc_step = acc + ACC_ONE;
            if (acc_step == ACC_POS) begin
               right_next = 1'b1;
               acc_next   = '0;
            end else begin
               acc_next = acc_step;
            end
         end
         DIR_CCW: begin
            acc_step = acc - ACC_ONE;
            if (acc_step == ACC_NEG) begin
               left_next = 1'b1;
               acc_next  = '0;
            end else begin
               acc_next = acc_step;
            end
         end
         // A skipped state means the phase is unknown; restart the detent.
         DIR_ERR:  acc_next = '0;
         default:  acc_next = acc;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         prev    <= 2'b00;
         acc     <= '0;
         o_Left  <= 1'b0;
         o_Right <= 1'b0;
      end else begin
         prev    <= ab_filt;
         acc     <= acc_next;
         o_Left  <= left_next;
         o_Right <= right_next;
      end
   end

endmodule

// File: tb/tb_quadrature_encoder.sv
// Directed bench for quadrature_encoder: two instances (4 and 1 steps per detent)
// share the A/B stimulus. Build with ENCODER_DEBOUNCE_EN to run the filter scenarios.
module tb_quadrature_encoder;

   logic clk = 1'b0;
   logic rst;
   logic a, b;
   logic l4, r4, l1, r1;

   always #5 clk = ~clk;

   quadrature_encoder #(.STEPS_PER_DETENT(4), .DEBOUNCE_CYCLES(8)) dut4 (
      .i_Clk (clk), .i_Rst (rst), .i_A (a), .i_B (b), .o_Left (l4), .o_Right (r4)
   );

   quadrature_encoder #(.STEPS_PER_DETENT(1), .DEBOUNCE_CYCLES(8)) dut1 (
      .i_Clk (clk), .i_Rst (rst), .i_A (a), .i_B (b), .o_Left (l1), .o_Right (r1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int r4_n = 0, l4_n = 0, r1_n = 0, l1_n = 0;
   int r4_at = -1;
   int wide_n = 0, both_n = 0;
   int b_r4, b_l4, b_r1, b_l1;
   int t_applied, t_ref;
   logic p_r4 = 0, p_l4 = 0, p_r1 = 0, p_l1 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (r4) begin r4_n++; r4_at = cyc; end
         if (l4) l4_n++;
         if (r1) r1_n++;
         if (l1) l1_n++;
         if ((p_r4 && r4) || (p_l4 && l4) || (p_r1 && r1) || (p_l1 && l1)) wide_n++;
         if ((r4 && l4) || (r1 && l1)) both_n++;
      end
      p_r4 = r4; p_l4 = l4; p_r1 = r1; p_l1 = l1;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic drive(input logic [1:0] ab, input int hold);
      {a, b} = ab;
      t_applied = cyc;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic mark();
      b_r4 = r4_n; b_l4 = l4_n; b_r1 = r1_n; b_l1 = l1_n;
   endtask

   task automatic cw_cycle(input int hold);
      drive(2'b10, hold);
      drive(2'b11, hold);
      drive(2'b01, hold);
      drive(2'b00, 0);
      t_ref = t_applied;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic ccw_cycle(input int hold);
      drive(2'b01, hold);
      drive(2'b11, hold);
      drive(2'b10, hold);
      drive(2'b00, hold);
   endtask

   task automatic release_reset();
      {a, b} = 2'b00;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a = 1'b0;
      b = 1'b0;

      // Reset holds outputs low even with the inputs toggling.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("rst_outputs", int'({l4, r4, l1, r1}), 0);
         {a, b} = 2'($urandom_range(0, 3));
      end
      release_reset();
      mark();
      drive(2'b00, 12);
      check_eq("idle_no_pulse", (r4_n - b_r4) + (l4_n - b_l4) + (r1_n - b_r1) + (l1_n - b_l1), 0);

`ifndef ENCODER_DEBOUNCE_EN
      // Clockwise detent.
      mark();
      cw_cycle(4);
      check_eq("cw_right4", r4_n - b_r4, 1);
      check_eq("cw_left4", l4_n - b_l4, 0);
      check_eq("cw_latency", r4_at - t_ref, 3);
      check_eq("cw_right1", r1_n - b_r1, 4);

      // Counter-clockwise detents.
      mark();
      ccw_cycle(4);
      check_eq("ccw_left4", l4_n - b_l4, 1);
      check_eq("ccw_right4", r4_n - b_r4, 0);
      check_eq("ccw_left1", l1_n - b_l1, 4);
      mark();
      ccw_cycle(4);
      ccw_cycle(4);
      check_eq("ccw2_left4", l4_n - b_l4, 2);

      // Reversal mid-detent returns to zero without a pulse.
      mark();
      drive(2'b10, 4);
      drive(2'b11, 4);
      drive(2'b10, 4);
      drive(2'b00, 6);
      check_eq("rev_pulses4", (r4_n - b_r4) + (l4_n - b_l4), 0);
      check_eq("rev_right1", r1_n - b_r1, 2);
      check_eq("rev_left1", l1_n - b_l1, 2);

      // Illegal jumps clear partial progress; the next detent starts from zero.
      mark();
      drive(2'b10, 4);
      drive(2'b11, 4);
      drive(2'b00, 4);
      drive(2'b11, 4);
      drive(2'b00, 4);
      check_eq("illegal_no_pulse4", (r4_n - b_r4) + (l4_n - b_l4), 0);
      cw_cycle(4);
      check_eq("illegal_then_cw4", r4_n - b_r4, 1);
      check_eq("illegal_then_cw_lat", r4_at - t_ref, 3);
      check_eq("illegal_left4", l4_n - b_l4, 0);

      // A pulse already high is dropped as soon as reset asserts.
      drive(2'b10, 4);
      drive(2'b11, 4);
      drive(2'b01, 4);
      {a, b} = 2'b00;
      repeat (3) @(posedge clk);
      #2;
      check_eq("flight_high", int'(r4), 1);
      rst = 1'b1;
      #1;
      check_eq("flight_reset_low", int'(r4), 0);
      repeat (3) @(posedge clk);
      release_reset();
      drive(2'b00, 4);

      // Reset mid-detent discards partial progress.
      drive(2'b10, 4);
      drive(2'b11, 4);
      drive(2'b01, 2);
      #1 rst = 1'b1;
      #1;
      check_eq("mid_rst_outputs", int'({l4, r4, l1, r1}), 0);
      repeat (3) @(posedge clk);
      release_reset();
      drive(2'b00, 4);
      mark();
      cw_cycle(4);
      check_eq("mid_rst_cw4", r4_n - b_r4, 1);
      check_eq("mid_rst_cw_lat", r4_at - t_ref, 3);
`else
      // A 5-cycle glitch on A never gets past the 8-cycle filter.
      mark();
      drive(2'b10, 5);
      drive(2'b00, 30);
      check_eq("glitch_pulses4", (r4_n - b_r4) + (l4_n - b_l4), 0);
      check_eq("glitch_pulses1", (r1_n - b_r1) + (l1_n - b_l1), 0);

      // Clean clockwise detent with 20-cycle steps.
      mark();
      cw_cycle(20);
      check_eq("db_cw_right4", r4_n - b_r4, 1);
      check_eq("db_cw_left4", l4_n - b_l4, 0);
      check_eq("db_cw_latency", r4_at - t_ref, 11);
      check_eq("db_cw_right1", r1_n - b_r1, 4);

      // Reset mid-detent: nothing until a whole new detent.
      drive(2'b10, 20);
      drive(2'b11, 10);
      #1 rst = 1'b1;
      #1;
      check_eq("db_rst_outputs", int'({l4, r4, l1, r1}), 0);
      repeat (3) @(posedge clk);
      release_reset();
      mark();
      drive(2'b00, 30);
      check_eq("db_rst_quiet4", (r4_n - b_r4) + (l4_n - b_l4), 0);
      cw_cycle(20);
      check_eq("db_rst_cw4", r4_n - b_r4, 1);
      check_eq("db_rst_cw_lat", r4_at - t_ref, 11);
`endif

      check_eq("pulse_width", wide_n, 0);
      check_eq("left_right_exclusive", both_n, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
